// File: rtl/lab_pkg.sv
// Shared definitions for the plot framebuffer.
//   SCREEN_W / SCREEN_H / FB_DEPTH : framebuffer geometry (160x120 = 19200 pixels)
//   ADDR_W                         : framebuffer address width
//   colour_t                       : 3-bit pixel colour
//   fb_state_t                     : clear controller states
//   fb_addr / fb_in_range          : coordinate helpers shared by plot and readback paths
package lab_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_DEPTH = 19200;
  localparam int ADDR_W   = 15;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } fb_state_t;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    return ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
  endfunction

  function automatic logic fb_in_range(input logic [7:0] x, input logic [6:0] y);
    return (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Framebuffer storage: simple dual-port synchronous RAM, FB_DEPTH x 3 bits.
//   clk     : clock
//   we      : write enable
//   wr_addr : write address
//   wr_data : write colour
//   rd_addr : read address (must be < FB_DEPTH)
//   rd_data : registered read data, read-first on a same-address collision
module fb_ram
  import lab_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  colour_t           wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output colour_t           rd_data
);

  colour_t mem [FB_DEPTH];

  // Read and write share one non-blocking update, so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/plot_fb.sv
// Plot framebuffer with full-screen clear controller, 1-cycle readback and
// optional statistics counters.
//   clk, rst                 : clock, synchronous active-high reset
//   vga_x/vga_y/vga_colour   : plot coordinate and colour, vga_plot strobes one pixel
//   clr_start/clr_colour     : request a full-screen fill with clr_colour
//   clr_done, busy           : clear finished (held until clr_start drops), clear running
//   rd_x/rd_y, rd_colour     : readback coordinate, pixel one cycle later (0 when off-screen)
//   plot_count/oob_count/drop_count : saturating statistics
// Build option: PLOT_FB_STATS_EN enables the counters; otherwise they read 0.
//
// state | meaning
// IDLE  | plots written, waiting for clr_start
// CLEAR | filling addresses 0..FB_DEPTH-1 with the latched colour, plots dropped
// DONE  | clear finished, clr_done high until clr_start is released
module plot_fb
  import lab_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       vga_x,
  input  logic [6:0]       vga_y,
  input  colour_t          vga_colour,
  input  logic             vga_plot,
  input  logic             clr_start,
  input  colour_t          clr_colour,
  output logic             clr_done,
  output logic             busy,
  input  logic [7:0]       rd_x,
  input  logic [6:0]       rd_y,
  output colour_t          rd_colour,
  output logic [CNT_W-1:0] plot_count,
  output logic [CNT_W-1:0] oob_count,
  output logic [CNT_W-1:0] drop_count
);

  fb_state_t         state, state_nxt;
  logic [ADDR_W-1:0] clr_addr;
  colour_t           clr_fill;
  logic              plot_ok;
  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] wr_addr;
  colour_t           wr_data;
  logic              rd_in;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ok;
  colour_t           ram_q;

  assign plot_ok = vga_plot && fb_in_range(vga_x, vga_y);
  assign accept  = !rst && (state == IDLE) && clr_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clr_addr <= '0;
      clr_fill <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        clr_fill <= clr_colour;
        clr_addr <= '0;
      end else if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    clr_done  = 1'b0;
    case (state)
      IDLE:  if (clr_start) state_nxt = CLEAR;
      CLEAR: begin
        busy = 1'b1;
        if (clr_addr == ADDR_W'(FB_DEPTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        clr_done = 1'b1;
        if (!clr_start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The clear owns the write port; plots are also held off on the accept cycle.
  always_comb begin
    ram_we  = 1'b0;
    wr_addr = clr_addr;
    wr_data = clr_fill;
    if (!rst) begin
      if (state == CLEAR) begin
        ram_we = 1'b1;
      end else if (plot_ok && !accept) begin
        ram_we  = 1'b1;
        wr_addr = fb_addr(vga_x, vga_y);
        wr_data = vga_colour;
      end
    end
  end

  // Off-screen reads are steered to address 0 and masked on the output.
  assign rd_in   = fb_in_range(rd_x, rd_y);
  assign rd_addr = rd_in ? fb_addr(rd_x, rd_y) : '0;

  always_ff @(posedge clk) begin
    if (rst) rd_ok <= 1'b0;
    else     rd_ok <= rd_in;
  end

  assign rd_colour = rd_ok ? ram_q : '0;

  fb_ram u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

`ifdef PLOT_FB_STATS_EN
  logic             plot_inc, oob_inc, drop_inc;
  logic [CNT_W-1:0] plot_q, oob_q, drop_q;

  assign plot_inc = !rst && plot_ok && !accept && (state != CLEAR);
  assign oob_inc  = !rst && vga_plot && !fb_in_range(vga_x, vga_y);
  assign drop_inc = !rst && plot_ok && (accept || (state == CLEAR));

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + CNT_W'(1) : c;
  endfunction

  // On the accept cycle the counters restart, so a coincident plot leaves them at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      plot_q <= '0;
      oob_q  <= '0;
      drop_q <= '0;
    end else if (accept) begin
      plot_q <= CNT_W'(plot_inc);
      oob_q  <= CNT_W'(oob_inc);
      drop_q <= CNT_W'(drop_inc);
    end else begin
      plot_q <= bump(plot_q, plot_inc);
      oob_q  <= bump(oob_q, oob_inc);
      drop_q <= bump(drop_q, drop_inc);
    end
  end

  assign plot_count = plot_q;
  assign oob_count  = oob_q;
  assign drop_count = drop_q;
`else
  assign plot_count = '0;
  assign oob_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_plot_fb.sv
module tb_plot_fb;

  localparam int CW = 4;
`ifdef PLOT_FB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot;
  logic          clr_start;
  logic [2:0]    clr_colour;
  logic          clr_done;
  logic          busy;
  logic [7:0]    rd_x;
  logic [6:0]    rd_y;
  logic [2:0]    rd_colour;
  logic [CW-1:0] plot_count, oob_count, drop_count;

  plot_fb #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .clr_start  (clr_start),
    .clr_colour (clr_colour),
    .clr_done   (clr_done),
    .busy       (busy),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_colour  (rd_colour),
    .plot_count (plot_count),
    .oob_count  (oob_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [CW-1:0] pc;
    logic [CW-1:0] oc;
    logic [CW-1:0] dc;
  } sts_t;

  int n_chk = 0;
  int n_fail = 0;

  logic  rd_req = 1'b0;
  logic  sts_req = 1'b0;
  logic [2:0] rd_exp_q[$];
  string      rd_name_q[$];
  sts_t       sts_exp_q[$];
  string      sts_name_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents just after each edge.
  always @(posedge clk) begin
    #1;
    if (rd_req) begin
      if (rd_exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_queue: read presented with no expected value");
      end else begin
        chk(rd_name_q.pop_front(), 32'(rd_colour), 32'(rd_exp_q.pop_front()));
      end
    end
    if (sts_req) begin
      if (sts_exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sts_queue: status presented with no expected value");
      end else begin
        sts_t  e;
        string nm;
        e  = sts_exp_q.pop_front();
        nm = sts_name_q.pop_front();
        chk({nm, ".busy"},  32'(busy),       32'(e.busy));
        chk({nm, ".done"},  32'(clr_done),   32'(e.done));
        chk({nm, ".plot"},  32'(plot_count), STATS ? 32'(e.pc) : 32'd0);
        chk({nm, ".oob"},   32'(oob_count),  STATS ? 32'(e.oc) : 32'd0);
        chk({nm, ".drop"},  32'(drop_count), STATS ? 32'(e.dc) : 32'd0);
      end
    end
  end

  task automatic rd(input int x, input int y, input logic [2:0] exp, input string nm);
    rd_x = 8'(x); rd_y = 7'(y); rd_req = 1'b1;
    rd_exp_q.push_back(exp); rd_name_q.push_back(nm);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic sts(input string nm, input logic b, input logic d,
                     input int pc, input int oc, input int dc);
    sts_t e;
    e.busy = b; e.done = d; e.pc = CW'(pc); e.oc = CW'(oc); e.dc = CW'(dc);
    sts_exp_q.push_back(e); sts_name_q.push_back(nm);
    sts_req = 1'b1;
    @(negedge clk);
    sts_req = 1'b0;
  endtask

  task automatic plot(input int x, input int y, input logic [2:0] c);
    vga_x = 8'(x); vga_y = 7'(y); vga_colour = c; vga_plot = 1'b1;
    @(negedge clk);
    vga_plot = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    clr_start = 1'b0; clr_colour = '0; rd_x = '0; rd_y = '0;
    @(negedge clk); @(negedge clk);
    rd(10, 10, 3'd0, "rd_in_reset");
    sts("reset", 1'b0, 1'b0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clear to colour 1, with drops and one off-screen plot while it runs.
    clr_colour = 3'd1; clr_start = 1'b1;
    @(negedge clk);
    clr_colour = 3'd6;
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      if (n >= 100 && n <= 109) begin
        vga_x = 8'(n - 100); vga_y = 7'd0; vga_colour = 3'd7; vga_plot = 1'b1;
      end else if (n == 110) begin
        vga_x = 8'd200; vga_y = 7'd5;
      end else if (n == 111) begin
        vga_plot = 1'b0;
      end
      if (n == 300) begin
        rd_x = 8'd0; rd_y = 7'd0; rd_req = 1'b1;
        rd_exp_q.push_back(3'd1); rd_name_q.push_back("rd_during_clear");
      end else if (n == 301) begin
        rd_req = 1'b0;
      end
      @(negedge clk);
    end
    chk("clear_cycles", 32'(n), 32'd19200);
    sts("done_hold", 1'b0, 1'b1, 0, 1, 10);
    rd(0, 0, 3'd1, "clr_0_0");
    rd(5, 0, 3'd1, "clr_5_0");
    rd(9, 0, 3'd1, "clr_9_0");
    rd(159, 119, 3'd1, "clr_159_119");
    rd(80, 60, 3'd1, "clr_80_60");
    clr_start = 1'b0;
    sts("done_release", 1'b0, 1'b0, 0, 1, 10);

    // Back-to-back in-range plots.
    plot(0, 0, 3'd7);
    plot(159, 119, 3'd5);
    plot(80, 60, 3'd2);
    rd(0, 0, 3'd7, "plot_0_0");
    rd(159, 119, 3'd5, "plot_159_119");
    rd(80, 60, 3'd2, "plot_80_60");
    rd(80, 61, 3'd1, "neighbour_80_61");
    rd(160, 0, 3'd0, "rd_oob_x");
    sts("plots", 1'b0, 1'b0, 3, 1, 10);

    // Off-screen plots must not alias onto real pixels.
    plot(160, 0, 3'd3);
    plot(0, 120, 3'd4);
    rd(0, 0, 3'd7, "after_oob_0_0");
    rd(159, 0, 3'd1, "after_oob_159_0");
    rd(0, 119, 3'd1, "rd_oob_y_alias");
    rd(0, 120, 3'd0, "rd_oob_y");
    sts("oob", 1'b0, 1'b0, 3, 3, 10);

    // Read and write to the same pixel on one cycle returns the old colour.
    vga_x = 8'd1; vga_y = 7'd1; vga_colour = 3'd6; vga_plot = 1'b1;
    rd(1, 1, 3'd1, "read_first_old");
    vga_plot = 1'b0;
    rd(1, 1, 3'd6, "read_first_new");

    // Clear to colour 4 with a plot on the accept cycle, reset at cycle 5000.
    clr_colour = 3'd4; clr_start = 1'b1;
    vga_x = 8'd2; vga_y = 7'd2; vga_colour = 3'd3; vga_plot = 1'b1;
    @(negedge clk);
    clr_start = 1'b0; vga_plot = 1'b0;
    for (int i = 0; i < 4999; i++) @(negedge clk);
    sts("clr2_mid", 1'b1, 1'b0, 0, 0, 1);
    rst = 1'b1; clr_start = 1'b1;
    vga_x = 8'd3; vga_y = 7'd3; vga_colour = 3'd7; vga_plot = 1'b1;
    sts("rst_mid_clear", 1'b0, 1'b0, 0, 0, 0);
    rst = 1'b0; clr_start = 1'b0; vga_plot = 1'b0;
    sts("post_rst_idle", 1'b0, 1'b0, 0, 0, 0);
    rd(0, 0, 3'd4, "partial_0_0");
    rd(2, 2, 3'd4, "partial_2_2");
    rd(3, 3, 3'd4, "rst_plot_ignored");
    rd(159, 119, 3'd5, "partial_159_119_old");
    rd(80, 60, 3'd2, "partial_80_60_old");

    // Saturation: 16 off-screen plots then 17 consecutive on-screen plots.
    for (int i = 0; i < 16; i++) begin
      vga_x = 8'(200 + i); vga_y = 7'd0; vga_colour = 3'd1; vga_plot = 1'b1;
      @(negedge clk);
    end
    for (int i = 10; i <= 26; i++) begin
      vga_x = 8'(i); vga_y = 7'd100; vga_colour = 3'((i + 1) % 8); vga_plot = 1'b1;
      @(negedge clk);
    end
    vga_plot = 1'b0;
    sts("saturate", 1'b0, 1'b0, 15, 15, 0);
    rd(10, 100, 3'd3, "burst_10_100");
    rd(17, 100, 3'd2, "burst_17_100");
    rd(26, 100, 3'd3, "burst_26_100");
    rd(27, 100, 3'd1, "burst_27_100_untouched");

    @(negedge clk); @(negedge clk);
    if (rd_exp_q.size() != 0 || sts_exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL queue_drain: %0d reads and %0d status checks left", rd_exp_q.size(), sts_exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
